// File: rtl/generic_bus_mem_responder_if.sv
// Generic request/response bus between a requester (cache) and a memory responder.
// Requests are held until the responder drops busy for one cycle.
interface generic_bus_if;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;

  modport generic_bus (
    input  addr, ren, wen, wdata, byte_en,
    output rdata, busy
  );

  modport master (
    output addr, ren, wen, wdata, byte_en,
    input  rdata, busy
  );
endinterface

// File: rtl/generic_bus_mem_responder.sv
// Word-addressed RAM window answering generic_bus_if requests after a programmable
// number of wait states, with byte enables and a sticky out-of-window flag.
module generic_bus_mem_responder #(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 2,
  parameter logic [31:0] ERR_DATA      = 32'hBAD1_BAD1
) (
  input  logic                    CLK,
  input  logic                    RST,
  generic_bus_if.generic_bus      bus_if,
  output logic                    err,
  output logic [31:0]             txn_count
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]  RD_LAT  = 4'(READ_LATENCY);
  localparam logic [3:0]  WR_LAT  = 4'(WRITE_LATENCY);
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'(DEPTH) * 33'd4);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        be_r;
  logic              wr_r;
  logic [31:0]       mem [DEPTH];

  logic              req_s;
  logic [3:0]        lat_s;
  logic              done_s;
  logic [31:0]       cur_addr_s;
  logic [31:0]       cur_wdata_s;
  logic [3:0]        cur_be_s;
  logic              cur_wr_s;
  logic              in_win_s;
  logic [IDX_W-1:0]  idx_s;

  // A simultaneous ren+wen is a write, so the live wen alone picks the latency.
  assign req_s = bus_if.ren | bus_if.wen;
  assign lat_s = bus_if.wen ? WR_LAT : RD_LAT;

  // Live bus fields are used in IDLE (zero-latency path), latched ones while waiting.
  always_comb begin
    if (state_r == WAIT) begin
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_be_s    = be_r;
      cur_wr_s    = wr_r;
      done_s      = !RST && req_s && (cnt_r == 4'd0);
    end else begin
      cur_addr_s  = bus_if.addr;
      cur_wdata_s = bus_if.wdata;
      cur_be_s    = bus_if.byte_en;
      cur_wr_s    = bus_if.wen;
      done_s      = !RST && req_s && (lat_s == 4'd0);
    end
  end

  // 33-bit compare keeps a window at the top of the address map from wrapping.
  assign in_win_s = ({1'b0, cur_addr_s} >= {1'b0, BASE_ADDR}) && ({1'b0, cur_addr_s} < WIN_END);
  assign idx_s    = IDX_W'((cur_addr_s - BASE_ADDR) >> 2);

  // Response: data only in the completing cycle of a read, zero otherwise.
  always_comb begin
    bus_if.busy = !done_s;
    if (done_s && !cur_wr_s) begin
      if (in_win_s) begin
        bus_if.rdata = mem[idx_s];
      end else begin
        bus_if.rdata = ERR_DATA;
      end
    end else begin
      bus_if.rdata = 32'h0000_0000;
    end
  end

  // Request sequencing, completion counting and the sticky window error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      be_r      <= 4'h0;
      wr_r      <= 1'b0;
      err       <= 1'b0;
      txn_count <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            addr_r  <= bus_if.addr;
            wdata_r <= bus_if.wdata;
            be_r    <= bus_if.byte_en;
            wr_r    <= bus_if.wen;
            if (lat_s != 4'd0) begin
              state_r <= WAIT;
              cnt_r   <= lat_s - 4'd1;
            end
          end
        end
        WAIT: begin
          if (!req_s) begin
            state_r <= IDLE;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (done_s) begin
        txn_count <= txn_count + 32'd1;
        if (!in_win_s) begin
          err <= 1'b1;
        end
      end
    end
  end

  // Byte-lane write at the completion edge; RAM contents survive reset.
  always_ff @(posedge CLK) begin
    if (done_s && cur_wr_s && in_win_s) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be_s[i]) begin
          mem[idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Bench for generic_bus_mem_responder: two configurations checked against a
// transaction-level memory model, directed tables and multi-cycle corner sequences.
module tb_generic_bus_mem_responder;

  localparam logic [31:0] ERR_W = 32'hBAD1_BAD1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       ren_d, wen_d, busy_v, err_v;
  logic [1:0][31:0] addr_d, wdata_d, rdata_v, txn_v;
  logic [1:0][3:0]  be_d;

  generic_bus_if bus0();
  generic_bus_if bus1();

  assign bus0.ren = ren_d[0];  assign bus0.wen = wen_d[0];
  assign bus0.addr = addr_d[0]; assign bus0.wdata = wdata_d[0]; assign bus0.byte_en = be_d[0];
  assign bus1.ren = ren_d[1];  assign bus1.wen = wen_d[1];
  assign bus1.addr = addr_d[1]; assign bus1.wdata = wdata_d[1]; assign bus1.byte_en = be_d[1];
  assign busy_v[0] = bus0.busy; assign rdata_v[0] = bus0.rdata;
  assign busy_v[1] = bus1.busy; assign rdata_v[1] = bus1.rdata;

  generic_bus_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(2),
    .WRITE_LATENCY(2), .ERR_DATA(ERR_W)) u0 (
    .CLK(clk), .RST(rst), .bus_if(bus0), .err(err_v[0]), .txn_count(txn_v[0]));

  generic_bus_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h0000_0100), .READ_LATENCY(1),
    .WRITE_LATENCY(0), .ERR_DATA(ERR_W)) u1 (
    .CLK(clk), .RST(rst), .bus_if(bus1), .err(err_v[1]), .txn_count(txn_v[1]));

  // Reference model: plain word arrays plus expected counters per responder.
  logic [31:0] m [2][1024];
  int          exp_txn [2];
  bit          exp_err [2];
  int          tests = 0;
  int          fails = 0;
  int          last_done = 0;

  function automatic longint base_of(input int d);
    return (d == 0) ? 64'h0 : 64'h100;
  endfunction
  function automatic longint depth_of(input int d);
    return (d == 0) ? 64'd1024 : 64'd16;
  endfunction
  function automatic int lat_of(input int d, input bit wr);
    if (d == 0) return 2;
    return wr ? 0 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, output logic [31:0] rd);
    int start, lat, idx;
    bit inw;
    logic [31:0] exp_rd;
    inw = (longint'(a) >= base_of(d)) && (longint'(a) < base_of(d) + depth_of(d) * 4);
    idx = inw ? int'((longint'(a) - base_of(d)) / 4) : 0;
    exp_rd = inw ? m[d][idx] : ERR_W;
    ren_d[d] = r; wen_d[d] = w; addr_d[d] = a; wdata_d[d] = wd; be_d[d] = be;
    start = cyc;
    lat = -1;
    rd = 32'h0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy_v[d] === 1'b0) begin
        lat = cyc - start;
        last_done = cyc;
        rd = rdata_v[d];
        break;
      end
      chk($sformatf("rdata_zero_while_busy d%0d", d), rdata_v[d], 32'h0);
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      tests++; fails++;
      $display("FAIL timeout d%0d addr %h: busy never dropped, required within 40 cycles", d, a);
      @(posedge clk); #1;
    end else begin
      chk($sformatf("latency d%0d addr %h", d, a), 32'(lat), 32'(lat_of(d, w)));
      @(posedge clk); #1;
      exp_txn[d]++;
      if (!inw) exp_err[d] = 1'b1;
      else if (w) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m[d][idx][8*i +: 8] = wd[8*i +: 8];
      end
      if (!w) chk($sformatf("model_rdata d%0d addr %h", d, a), rd, exp_rd);
    end
    ren_d[d] = 1'b0; wen_d[d] = 1'b0;
    chk($sformatf("txn_count d%0d", d), txn_v[d], 32'(exp_txn[d]));
    chk($sformatf("err d%0d", d), {31'h0, err_v[d]}, {31'h0, exp_err[d]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ren_d = 2'b00; wen_d = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_txn[d] = 0;
      exp_err[d] = 1'b0;
    end
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int t0, d, op, nw;
    logic [31:0] a;

    tbl[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEAD_BEEF, 4'hF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,         4'hF, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h10,       32'h1122_3344, 4'hF, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h10,       32'hAABB_CCDD, 4'h5, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h10,       32'h0,         4'h0, 32'h11BB_33DD};
    tbl[5]  = '{1'b1, 1'b0, 32'h13,       32'h0,         4'h0, 32'h11BB_33DD};
    tbl[6]  = '{1'b0, 1'b1, 32'h0,        32'h1234_5678, 4'hF, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h1000,     32'h0,         4'hF, ERR_W};
    tbl[8]  = '{1'b0, 1'b1, 32'h1000,     32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,        32'h0,         4'hF, 32'h1234_5678};
    tbl[10] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'hF, ERR_W};

    addr_d = '0; wdata_d = '0; be_d = '0;
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset busy d%0d", i), {31'h0, busy_v[i]}, 32'h1);
      chk($sformatf("reset rdata d%0d", i), rdata_v[i], 32'h0);
      chk($sformatf("reset err d%0d", i), {31'h0, err_v[i]}, 32'h0);
      chk($sformatf("reset txn d%0d", i), txn_v[i], 32'h0);
    end

    for (int i = 0; i < 11; i++) begin
      run(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].be, rd);
      if (tbl[i].r) chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp);
      if (i == 1) chk("basic txn_count", txn_v[0], 32'd2);
    end
    chk("err held after window miss", {31'h0, err_v[0]}, 32'h1);

    // Zero-latency ren+wen is a write on the second responder
    run(1, 1'b1, 1'b1, 32'h108, 32'h5, 4'hF, rd);
    run(1, 1'b1, 1'b0, 32'h108, 32'h0, 4'hF, rd);
    chk("zero-lat write readback", rd, 32'h5);

    // Prefill the words the random phase reads
    for (int i = 0; i < 32; i++) run(0, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);
    for (int i = 0; i < 16; i++) run(1, 1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, rd);

    // Burst: ren held, address advanced on each busy-low cycle
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      run(0, 1'b1, 1'b0, 32'h40 + 32'(i * 4), 32'h0, 4'hF, rd);
      chk($sformatf("burst%0d completion cycle", i), 32'(last_done - t0), 32'(2 + 3 * i));
    end

    // Abort a write in WAIT
    ren_d[0] = 1'b0; wen_d[0] = 1'b1; addr_d[0] = 32'h20; wdata_d[0] = 32'h0BAD_F00D; be_d[0] = 4'hF;
    @(posedge clk); #1;
    wen_d[0] = 1'b0;
    @(negedge clk);
    chk("abort write busy", {31'h0, busy_v[0]}, 32'h1);
    @(posedge clk); #1;
    chk("abort write txn_count", txn_v[0], 32'(exp_txn[0]));
    run(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd);

    // Abort a read exactly when its count reaches zero
    ren_d[1] = 1'b1; addr_d[1] = 32'h104;
    @(posedge clk); #1;
    ren_d[1] = 1'b0;
    @(negedge clk);
    chk("abort read busy", {31'h0, busy_v[1]}, 32'h1);
    @(posedge clk); #1;
    chk("abort read txn_count", txn_v[1], 32'(exp_txn[1]));

    // Reset during the completion cycle of a write
    wen_d[0] = 1'b1; addr_d[0] = 32'h24; wdata_d[0] = 32'hCAFE_0000; be_d[0] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wen_d[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_txn[i] = 0;
      exp_err[i] = 1'b0;
    end
    chk("rst-in-wait busy", {31'h0, busy_v[0]}, 32'h1);
    chk("rst-in-wait rdata", rdata_v[0], 32'h0);
    chk("rst-in-wait txn_count", txn_v[0], 32'h0);
    chk("rst-in-wait err", {31'h0, err_v[0]}, 32'h0);
    run(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, rd);

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      nw = (d == 0) ? 32 : 16;
      if ($urandom_range(0, 7) == 0)
        a = (d == 0) ? (32'h1000 + 32'($urandom_range(0, 255)) * 4) : ($urandom_range(0, 1) ? 32'hFC : 32'h140);
      else
        a = 32'(base_of(d)) + 32'($urandom_range(0, nw - 1)) * 4 + 32'($urandom_range(0, 3));
      run(d, (op != 1), (op != 0), a, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
